// File: rtl/scaler_ctrl.sv
// scaler_ctrl: buffers synth samples from a ready/valid producer and hands one
// sample/shift pair to the output scaler every CLKS_PER_SAMPLE cycles.
// Optional feature macro: SCALER_AUTO_GAIN_EN (clip detection + automatic
// shift back-off). Without it, clip is tied low and no clip logic exists.
module scaler_ctrl #(
    parameter int         CLKS_PER_SAMPLE = 1024,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [4:0] DEFAULT_SHIFT   = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] sample_in,
    input  logic        sample_in_valid,
    output logic        sample_in_ready,
    input  logic [4:0]  shift_cfg,
    input  logic        shift_cfg_wr,
    output logic [13:0] synth_out,
    output logic [4:0]  synth_shift,
    output logic        sample_tick,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        clip
);

    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam int            CW        = $clog2(CLKS_PER_SAMPLE);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_SAMPLE - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   PRIME_CNT = (AW+1)'(FIFO_DEPTH / 2);

    typedef enum logic {PRIME, RUN} state_t;

    logic [13:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    pend_shift_q, pend_shift_d;
    logic [4:0]    synth_shift_q, synth_shift_d;
    logic [13:0]   synth_out_q, synth_out_d;
    logic          sample_tick_q, sample_tick_d;
    logic          underflow_q, underflow_d;
    logic [4:0]    applied_shift;
    logic [13:0]   head;
    logic          full, empty, push, load, pop;

    // Ready depends only on occupancy, so a full buffer refuses even on a pop edge.
    assign full            = (occ_q == FULL_CNT);
    assign empty           = (occ_q == '0);
    assign sample_in_ready = !full && !rst;
    assign push            = sample_in_valid && sample_in_ready;
    assign load            = (state_q == RUN) && (cnt_q == LAST);
    assign pop             = load && !empty;
    assign head            = mem_q[rd_ptr_q];
    // A write strobe coincident with a load is honoured by that same load.
    assign applied_shift   = shift_cfg_wr ? shift_cfg : pend_shift_q;

`ifdef SCALER_AUTO_GAIN_EN
    logic clip_hit;
    logic clip_q, clip_d;

    // Sample overflows when the k+1 top bits are not all copies of the sign bit.
    always_comb begin
        clip_hit = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i >= 13 - int'(applied_shift))
                clip_hit = clip_hit | (head[i] != head[13]);
        end
    end

    assign clip = clip_q;
`else
    assign clip = 1'b0;
`endif

    // Next-state: FIFO pointers, period counter, FSM, and the output pair.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_shift_d  = shift_cfg_wr ? shift_cfg : pend_shift_q;
        synth_shift_d = synth_shift_q;
        synth_out_d   = synth_out_q;
        sample_tick_d = load;
        underflow_d   = underflow_clr ? 1'b0 : underflow_q;
`ifdef SCALER_AUTO_GAIN_EN
        clip_d        = 1'b0;
`endif
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case (state_q)
            PRIME: begin
                cnt_d = '0;
                if (occ_d >= PRIME_CNT) state_d = RUN;
            end
            RUN: begin
                if (load) begin
                    cnt_d = '0;
                    if (empty) begin
                        // Starved: emit silence, keep the shift, re-prime.
                        synth_out_d = '0;
                        underflow_d = 1'b1;
                        state_d     = PRIME;
                    end else begin
                        synth_out_d   = head;
                        synth_shift_d = applied_shift;
`ifdef SCALER_AUTO_GAIN_EN
                        clip_d = clip_hit;
                        // Back off one step for the next load unless software wrote now.
                        if (clip_hit && !shift_cfg_wr)
                            pend_shift_d = (applied_shift == 5'd0) ? 5'd0 : applied_shift - 5'd1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = PRIME;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            state_q       <= PRIME;
            cnt_q         <= '0;
            pend_shift_q  <= DEFAULT_SHIFT;
            synth_shift_q <= DEFAULT_SHIFT;
            synth_out_q   <= '0;
            sample_tick_q <= 1'b0;
            underflow_q   <= 1'b0;
`ifdef SCALER_AUTO_GAIN_EN
            clip_q        <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_shift_q  <= pend_shift_d;
            synth_shift_q <= synth_shift_d;
            synth_out_q   <= synth_out_d;
            sample_tick_q <= sample_tick_d;
            underflow_q   <= underflow_d;
`ifdef SCALER_AUTO_GAIN_EN
            clip_q        <= clip_d;
`endif
        end
    end

    // Sample storage; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sample_in;
    end

    assign synth_out   = synth_out_q;
    assign synth_shift = synth_shift_q;
    assign sample_tick = sample_tick_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_scaler_ctrl.sv
// Directed bench for scaler_ctrl (CLKS_PER_SAMPLE=8, FIFO_DEPTH=4) with a
// sample scoreboard: accepted samples are queued, popped on each sample_tick.
module tb_scaler_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] sample_in;
    logic        sample_in_valid;
    logic        sample_in_ready;
    logic [4:0]  shift_cfg;
    logic        shift_cfg_wr;
    logic [13:0] synth_out;
    logic [4:0]  synth_shift;
    logic        sample_tick;
    logic        underflow;
    logic        underflow_clr;
    logic        clip;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [13:0] sb [$];

    scaler_ctrl #(
        .CLKS_PER_SAMPLE(8),
        .FIFO_DEPTH     (4),
        .DEFAULT_SHIFT  (5'd4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_in_valid(sample_in_valid),
        .sample_in_ready(sample_in_ready),
        .shift_cfg      (shift_cfg),
        .shift_cfg_wr   (shift_cfg_wr),
        .synth_out      (synth_out),
        .synth_shift    (synth_shift),
        .sample_tick    (sample_tick),
        .underflow      (underflow),
        .underflow_clr  (underflow_clr),
        .clip           (clip)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sample and wait (bounded) until it transfers.
    task automatic push_one(input logic [13:0] s);
        int n = 0;
        sample_in_valid = 1'b1;
        sample_in       = s;
        while (!sample_in_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready_timeout", 32'(n < 50), 32'd1);
        step();
        sb.push_back(s);
        sample_in_valid = 1'b0;
    endtask

    // Compare the loaded value against the scoreboard head (or silence if starved).
    task automatic check_tick(input string tag, input logic exp_clip);
        logic [13:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_out"}, 32'(synth_out), 32'(e));
        end else begin
            chk({tag, "_out0"}, 32'(synth_out), 32'd0);
            chk({tag, "_uflow"}, 32'(underflow), 32'd1);
        end
        chk({tag, "_clip"}, 32'(clip), 32'(exp_clip));
    endtask

    task automatic wait_load(input int exp_n, input string tag, input logic exp_clip);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < 40);
        chk({tag, "_lat"}, 32'(n), 32'(exp_n));
        check_tick(tag, exp_clip);
    endtask

    task automatic idle_no_tick(input int cycles, input string tag);
        int ticks = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (sample_tick) ticks++;
        end
        chk(tag, 32'(ticks), 32'd0);
    endtask

    task automatic clear_underflow();
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        chk("uflow_clr", 32'(underflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] es [6];
        int          acc [6];
        int          idx, cyc;
        logic        rdy;

        rst = 1'b1; sample_in = '0; sample_in_valid = 1'b0;
        shift_cfg = '0; shift_cfg_wr = 1'b0; underflow_clr = 1'b0;
        step(); step();

        // Reset state
        chk("rst_out",   32'(synth_out),       32'd0);
        chk("rst_shift", 32'(synth_shift),     32'd4);
        chk("rst_tick",  32'(sample_tick),     32'd0);
        chk("rst_uflow", 32'(underflow),       32'd0);
        chk("rst_clip",  32'(clip),            32'd0);
        chk("rst_ready", 32'(sample_in_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(sample_in_ready), 32'd1);

        // Prime with two samples, two loads 8 cycles apart, then starvation
        push_one(14'h0123);
        push_one(14'h3F00);
        wait_load(8, "load1", 1'b0);
        chk("load1_shift", 32'(synth_shift), 32'd4);
        wait_load(8, "load2", 1'b0);
        wait_load(8, "uflow_load", 1'b0);
        idle_no_tick(20, "prime_no_tick");
        chk("uflow_sticky", 32'(underflow), 32'd1);
        clear_underflow();

        // Mid-period shift write is held until the load edge
        push_one(14'h0001);
        push_one(14'h0002);
        step(); step(); step();
        shift_cfg = 5'd7; shift_cfg_wr = 1'b1;
        step();
        shift_cfg_wr = 1'b0;
        chk("shift_held", 32'(synth_shift), 32'd4);
        wait_load(4, "shift_load", 1'b0);
        chk("shift_applied", 32'(synth_shift), 32'd7);
        wait_load(8, "shift_load2", 1'b0);
        wait_load(8, "shift_uflow", 1'b0);
        chk("uflow_keeps_shift", 32'(synth_shift), 32'd7);
        clear_underflow();

        // Backpressure: hold valid across 6 samples
        es = '{14'h0010, 14'h0011, 14'h0012, 14'h0013, 14'h0014, 14'h0015};
        acc = '{default: -1};
        idx = 0; cyc = 0;
        sample_in_valid = 1'b1;
        sample_in = es[0];
        while (idx < 6 && cyc < 60) begin
            rdy = sample_in_ready;
            step();
            if (rdy) begin
                sb.push_back(es[idx]);
                acc[idx] = cyc;
                idx++;
                if (idx < 6) sample_in = es[idx];
            end
            if (sample_tick) check_tick("stream", 1'b0);
            cyc++;
        end
        sample_in_valid = 1'b0;
        chk("stream_all",  32'(idx),    32'd6);
        chk("stream_acc3", 32'(acc[3]), 32'd3);
        chk("stream_acc4", 32'(acc[4]), 32'd10);
        chk("stream_acc5", 32'(acc[5]), 32'd18);
        wait_load(7, "stream_load3", 1'b0);

        // Reset mid-period with 3 samples still buffered
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("mrst_out",   32'(synth_out),       32'd0);
        chk("mrst_shift", 32'(synth_shift),     32'd4);
        chk("mrst_tick",  32'(sample_tick),     32'd0);
        chk("mrst_ready", 32'(sample_in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        idle_no_tick(20, "mrst_no_tick");
        chk("mrst_ready_back", 32'(sample_in_ready), 32'd1);
        push_one(14'h0055);
        push_one(14'h3FAA);
        wait_load(8, "reprime_load", 1'b0);
        chk("reprime_shift", 32'(synth_shift), 32'd4);
        wait_load(8, "reprime_load2", 1'b0);
        wait_load(8, "reprime_uflow", 1'b0);
        clear_underflow();

`ifdef SCALER_AUTO_GAIN_EN
        // Clip at shift 4 backs the next load off to shift 3
        push_one(14'h0400);
        push_one(14'h0100);
        wait_load(8, "ag_clip", 1'b1);
        chk("ag_shift4", 32'(synth_shift), 32'd4);
        wait_load(8, "ag_noclip", 1'b0);
        chk("ag_shift3", 32'(synth_shift), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
